// File: rtl/phase_b.sv
// Final conditional subtraction: reduces a (< 2m) into [0, m) with a
// digit-serial a - m, LSB digit first, then selects a - m or a on the final borrow.
module phase_b #(
  parameter int WIDTH = 3072,
  parameter int DIGIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             en,
  output logic [WIDTH-1:0] new_a,
  output logic             en_out,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_diff;
  logic [WIDTH-1:0]   r_new_a;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic               r_en_out;
  logic               r_busy;
  logic               w_load;
  logic               w_step;
  logic               w_done;
  logic               w_last;
  logic [DIGIT:0]     w_d;

  assign w_last = (r_cnt == CNT_W'(N - 1));

  // Handshake: en is a start strobe honoured only in IDLE (never while busy);
  // en_out is a one-cycle strobe marking new_a valid, with no backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_next = S_SUB;
      S_SUB:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  w_load = en;
      S_SUB:   w_step = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Operands rotate one digit per step, so digit cnt always sits at bit 0 and
  // a_reg is back in its original order after N steps, ready for selection.
  assign w_d = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_m[DIGIT-1:0]} - (DIGIT+1)'(r_borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_m      <= '0;
      r_diff   <= '0;
      r_new_a  <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_en_out <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_en_out <= w_done;
      r_busy   <= (w_next != S_IDLE);
      if (w_load) begin
        r_a      <= a;
        r_m      <= m;
        r_cnt    <= '0;
        r_borrow <= 1'b0;
      end else if (w_step) begin
        r_a      <= {r_a[DIGIT-1:0], r_a[WIDTH-1:DIGIT]};
        r_m      <= {r_m[DIGIT-1:0], r_m[WIDTH-1:DIGIT]};
        r_diff   <= {w_d[DIGIT-1:0], r_diff[WIDTH-1:DIGIT]};
        r_borrow <= w_d[DIGIT];
        r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_done) r_new_a <= r_borrow ? r_a : r_diff;
    end
  end

  assign new_a       = r_new_a;
  assign en_out      = r_en_out;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_phase_b.sv
// Bench for phase_b: directed corner cases plus random operands, checked
// against a cycle-level arithmetic reference and an expected-result queue.
module tb_phase_b;

  localparam int WIDTH = 3072;
  localparam int DIGIT = 64;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] m_in;
  logic             en;
  logic [WIDTH-1:0] new_a;
  logic             en_out;
  logic             busy;
  logic [1:0]       dbg_state;

  phase_b #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a_in),
    .m           (m_in),
    .en          (en),
    .new_a       (new_a),
    .en_out      (en_out),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  int start_q[$];
  int out_cyc_q[$];
  int next_ok  = 0;
  int n_out    = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", tag, got[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_reduce(input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] mv);
    return (av >= mv) ? av - mv : av;
  endfunction

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // driver: pulse en so that it is sampled at edge tgt (or the next possible one)
  task automatic drive_en(input int tgt, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] mv);
    @(negedge clk);
    while (cyc + 1 < tgt) @(negedge clk);
    a_in = av;
    m_in = mv;
    en   = 1'b1;
    if (cyc + 1 >= next_ok) begin
      exp_q.push_back(ref_reduce(av, mv));
      start_q.push_back(cyc + 1);
      next_ok = cyc + 1 + N + 2;
    end
    @(posedge clk);
    #1;
    en   = 1'b0;
    a_in = rand_wide();
    m_in = rand_wide();
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // per-cycle monitor: busy window and en_out position come from accepted start edges
  always @(negedge clk) begin
    logic busy_exp;
    logic eo_exp;
    busy_exp = 1'b0;
    eo_exp   = 1'b0;
    while (start_q.size() > 0 && start_q[0] + N + 1 < cyc) void'(start_q.pop_front());
    foreach (start_q[i]) begin
      if (cyc >= start_q[i] && cyc <= start_q[i] + N) busy_exp = 1'b1;
      if (cyc == start_q[i] + N + 1) eo_exp = 1'b1;
    end
    check("busy", WIDTH'(busy), WIDTH'(busy_exp));
    check("en_out", WIDTH'(en_out), WIDTH'(eo_exp));
    if (en_out) begin
      n_out++;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() > 0) check("new_a", new_a, exp_q.pop_front());
    end
  end

  logic [WIDTH-1:0] m_t, a_t, a2_t, m2_t, one_w;
  int nb, e0, outs0, k, tgt;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a_in  = '0;
    m_in  = '0;
    one_w = WIDTH'(1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_new_a", new_a, '0);
    check("rst_en_out", WIDTH'(en_out), '0);
    check("rst_busy", WIDTH'(busy), '0);
    @(negedge clk) rst_n = 1'b1;

    // a = m + 5, latency and busy length
    m_t = rand_wide();
    m_t[WIDTH-1 -: 16] = 16'hdc85;
    m_t[15:0] = 16'hd004;
    drive_en(cyc + 2, m_t + WIDTH'(5), m_t);
    nb = 0;
    for (int i = 0; i < N + 5; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("busy_cycles", WIDTH'(nb), WIDTH'(N + 1));
    check("m_plus_5", new_a, WIDTH'(5));
    check("out_count_1", WIDTH'(n_out), WIDTH'(1));

    drive_en(cyc + 2, m_t - WIDTH'(1), m_t);
    wait_neg(N + 4);
    check("m_minus_1", new_a, m_t - WIDTH'(1));
    drive_en(cyc + 2, m_t, m_t);
    wait_neg(N + 4);
    check("a_eq_m", new_a, '0);
    drive_en(cyc + 2, '0, m_t);
    wait_neg(N + 4);
    check("a_zero", new_a, '0);

    // borrow ripple cases
    drive_en(cyc + 2, one_w << 64, one_w);
    wait_neg(N + 4);
    check("ripple_d0", new_a, (one_w << 64) - one_w);
    a_t = one_w << (WIDTH - 1);
    drive_en(cyc + 2, a_t, a_t + one_w);
    wait_neg(N + 4);
    check("final_borrow", new_a, a_t);

    // en during SUB (E10) and DONE (EN+1) must be ignored
    outs0 = n_out;
    a_t = rand_wide();
    m_t = rand_wide() | (one_w << (WIDTH - 1));
    e0 = cyc + 3;
    drive_en(e0, a_t, m_t);
    drive_en(e0 + 10, rand_wide(), rand_wide());
    drive_en(e0 + N + 1, rand_wide(), rand_wide());
    wait_neg(N + 6);
    check("ignore_outs", WIDTH'(n_out - outs0), WIDTH'(1));
    check("ignore_result", new_a, ref_reduce(a_t, m_t));

    // back-to-back at EN+2
    a2_t = rand_wide();
    m2_t = rand_wide() | (one_w << (WIDTH - 1));
    e0 = cyc + 3;
    drive_en(e0, a_t, m_t);
    drive_en(e0 + N + 2, a2_t, m2_t);
    wait_neg(N + 6);
    check("b2b_spacing",
          WIDTH'(out_cyc_q[out_cyc_q.size()-1] - out_cyc_q[out_cyc_q.size()-2]),
          WIDTH'(N + 2));
    check("b2b_result", new_a, ref_reduce(a2_t, m2_t));

    // reset at E20 of an operation
    e0 = cyc + 3;
    drive_en(e0, a_t, m_t);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    start_q.delete();
    next_ok = 0;
    #1;
    check("midrst_new_a", new_a, '0);
    check("midrst_en_out", WIDTH'(en_out), '0);
    check("midrst_busy", WIDTH'(busy), '0);
    @(negedge clk) rst_n = 1'b1;
    outs0 = n_out;
    wait_neg(100);
    check("midrst_no_out", WIDTH'(n_out), WIDTH'(outs0));
    drive_en(cyc + 2, a2_t, m2_t);
    wait_neg(N + 4);
    check("post_rst_result", new_a, ref_reduce(a2_t, m2_t));

    // random operands with a < 2m, random spacing including early (ignored) pulses
    for (int t = 0; t < 24; t++) begin
      k    = $urandom_range(0, WIDTH - 1);
      m_t  = (rand_wide() | (one_w << (WIDTH - 1))) >> k;
      a_t  = rand_wide() >> k;
      tgt  = next_ok + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) tgt = tgt - $urandom_range(1, 10);
      drive_en(tgt, a_t, m_t);
    end
    wait_neg(N + 6);
    check("drain", WIDTH'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
